// File: rtl/ep_databuffer_pkg.sv
// Shared transfer-size encoding and default geometry for the endpoint byte buffer.
package ep_buffer_pkg;

  localparam int DEF_NUM_EP = 4;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } xfer_size_t;

  // Bytes moved by one host access; the reserved encoding moves nothing.
  function automatic logic [2:0] xfer_bytes(input logic [1:0] size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      WORD:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ep_databuffer_if.sv
// Host (AHB) and USB side signals of the endpoint buffer; master drives requests, slave is the buffer.
interface ep_databuffer_if #(
  parameter int NUM_EP = ep_buffer_pkg::DEF_NUM_EP,
  parameter int DEPTH  = ep_buffer_pkg::DEF_DEPTH
);
  import ep_buffer_pkg::*;

  localparam int EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [EP_W-1:0]         ahb_ep;
  logic                    store_tx_data;
  logic [31:0]             tx_data;
  logic [1:0]              tx_size;
  logic                    get_rx_data;
  logic [1:0]              rx_size;
  logic [31:0]             rx_data;
  logic                    clear;
  logic [EP_W-1:0]         usb_ep;
  logic                    store_rx_packet_data;
  logic [7:0]              rx_packet_data;
  logic                    get_tx_packet_data;
  logic [7:0]              tx_packet_data;
  logic                    flush;
  logic [NUM_EP*OCC_W-1:0] buffer_occupancy;
  logic [NUM_EP-1:0]       overflow;
  logic [NUM_EP-1:0]       underflow;

  modport master (
    output ahb_ep, store_tx_data, tx_data, tx_size, get_rx_data, rx_size, clear,
    output usb_ep, store_rx_packet_data, rx_packet_data, get_tx_packet_data, flush,
    input  rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
  );

  modport slave (
    input  ahb_ep, store_tx_data, tx_data, tx_size, get_rx_data, rx_size, clear,
    input  usb_ep, store_rx_packet_data, rx_packet_data, get_tx_packet_data, flush,
    output rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
  );

endinterface

// File: rtl/ep_databuffer_fifo_ctrl.sv
// Pointer, occupancy and sticky-flag control for one endpoint FIFO; grants are combinational on
// pre-cycle occupancy, state moves on the next clk edge. Full/empty accesses are refused, never stalled.
module ep_fifo_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_push,
  input  logic [2:0]               host_push_n,
  input  logic                     host_pop,
  input  logic [2:0]               host_pop_n,
  input  logic                     usb_push,
  input  logic                     usb_pop,
  input  logic                     clear,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     host_push_ok,
  output logic                     host_pop_ok,
  output logic                     host_pop_fail,
  output logic                     usb_push_ok,
  output logic                     usb_pop_ok,
  output logic                     usb_pop_fail
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic             kill;
  logic             host_push_fail;
  logic             usb_push_fail;
  logic [OCC_W-1:0] free;
  logic [OCC_W-1:0] push_n;
  logic [OCC_W-1:0] pop_n;
  logic [OCC_W-1:0] push_cnt;
  logic [OCC_W-1:0] pop_cnt;

  // USB side wins any same-endpoint collision; clear/flush suppress everything, including flag updates.
  always_comb begin
    kill           = clear | flush;
    free           = OCC_W'(DEPTH) - occ;
    push_n         = OCC_W'(host_push_n);
    pop_n          = OCC_W'(host_pop_n);
    usb_push_ok    = usb_push & ~kill & (occ != OCC_W'(DEPTH));
    usb_push_fail  = usb_push & ~kill & ~usb_push_ok;
    host_push_ok   = host_push & ~usb_push & ~kill & (free >= push_n);
    host_push_fail = host_push & ~kill & ~host_push_ok;
    usb_pop_ok     = usb_pop & ~kill & (occ != '0);
    usb_pop_fail   = usb_pop & ~kill & ~usb_pop_ok;
    host_pop_ok    = host_pop & ~usb_pop & ~kill & (occ >= pop_n);
    host_pop_fail  = host_pop & ~kill & ~host_pop_ok;
    push_cnt       = usb_push_ok ? OCC_W'(1) : (host_push_ok ? push_n : '0);
    pop_cnt        = usb_pop_ok  ? OCC_W'(1) : (host_pop_ok  ? pop_n  : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr    <= wr_ptr + push_cnt[PTR_W-1:0];
      rd_ptr    <= rd_ptr + pop_cnt[PTR_W-1:0];
      occ       <= occ + push_cnt - pop_cnt;
      overflow  <= overflow | host_push_fail | usb_push_fail;
      underflow <= underflow | host_pop_fail | usb_pop_fail;
    end
  end

endmodule

// File: rtl/ep_databuffer.sv
// Multi-endpoint byte buffer between a host (1/2/4-byte access) and a USB engine (byte access).
// Read data is registered one cycle after the pop; full/empty accesses are dropped and flagged, never stalled.
module ep_databuffer
  import ep_buffer_pkg::*;
#(
  parameter int NUM_EP = DEF_NUM_EP,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic             clk,
  input logic             rst,
  ep_databuffer_if.slave  bus
);
  localparam int EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int AW    = EP_W + PTR_W;

  logic [7:0]                   mem [NUM_EP*DEPTH];
  logic [2:0]                   tx_n;
  logic [2:0]                   rx_n;
  logic [NUM_EP-1:0][PTR_W-1:0] wr_ptr;
  logic [NUM_EP-1:0][PTR_W-1:0] rd_ptr;
  logic [NUM_EP-1:0][OCC_W-1:0] occ;
  logic [NUM_EP-1:0]            host_push_ok, host_pop_ok, host_pop_fail;
  logic [NUM_EP-1:0]            usb_push_ok, usb_pop_ok, usb_pop_fail;
  logic [NUM_EP-1:0]            ovf, unf;
  logic [PTR_W-1:0]             ahb_wr, ahb_rd, usb_wr, usb_rd;
  logic [31:0]                  rd_word;
  logic [31:0]                  rx_q;
  logic [7:0]                   tx_q;

  // Endpoint regions are laid out back to back; the pointer wraps within its own region.
  function automatic logic [AW-1:0] addr(input logic [EP_W-1:0] ep, input logic [PTR_W-1:0] ptr,
                                         input logic [PTR_W-1:0] off);
    return {ep, ptr + off};
  endfunction

  assign tx_n = xfer_bytes(bus.tx_size);
  assign rx_n = xfer_bytes(bus.rx_size);

  for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
    logic host_sel;
    logic usb_sel;
    assign host_sel = (bus.ahb_ep == EP_W'(i));
    assign usb_sel  = (bus.usb_ep == EP_W'(i));

    ep_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .host_push     (bus.store_tx_data & host_sel & (tx_n != 3'd0)),
      .host_push_n   (tx_n),
      .host_pop      (bus.get_rx_data & host_sel & (rx_n != 3'd0)),
      .host_pop_n    (rx_n),
      .usb_push      (bus.store_rx_packet_data & usb_sel),
      .usb_pop       (bus.get_tx_packet_data & usb_sel),
      .clear         (bus.clear & host_sel),
      .flush         (bus.flush & usb_sel),
      .wr_ptr        (wr_ptr[i]),
      .rd_ptr        (rd_ptr[i]),
      .occ           (occ[i]),
      .overflow      (ovf[i]),
      .underflow     (unf[i]),
      .host_push_ok  (host_push_ok[i]),
      .host_pop_ok   (host_pop_ok[i]),
      .host_pop_fail (host_pop_fail[i]),
      .usb_push_ok   (usb_push_ok[i]),
      .usb_pop_ok    (usb_pop_ok[i]),
      .usb_pop_fail  (usb_pop_fail[i])
    );
  end

  always_comb begin
    ahb_wr = '0;
    ahb_rd = '0;
    usb_wr = '0;
    usb_rd = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (bus.ahb_ep == EP_W'(i)) begin
        ahb_wr = wr_ptr[i];
        ahb_rd = rd_ptr[i];
      end
      if (bus.usb_ep == EP_W'(i)) begin
        usb_wr = wr_ptr[i];
        usb_rd = rd_ptr[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(rx_n)) rd_word[8*k +: 8] = mem[addr(bus.ahb_ep, ahb_rd, PTR_W'(k))];
  end

  // At most one push is granted per endpoint, so the two write ports never hit the same byte.
  always_ff @(posedge clk) begin
    if (|usb_push_ok) mem[addr(bus.usb_ep, usb_wr, '0)] <= bus.rx_packet_data;
    if (|host_push_ok)
      for (int k = 0; k < 4; k++)
        if (k < int'(tx_n)) mem[addr(bus.ahb_ep, ahb_wr, PTR_W'(k))] <= bus.tx_data[8*k +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      if (|host_pop_ok)        rx_q <= rd_word;
      else if (|host_pop_fail) rx_q <= '0;
      if (|usb_pop_ok)         tx_q <= mem[addr(bus.usb_ep, usb_rd, '0)];
      else if (|usb_pop_fail)  tx_q <= '0;
    end
  end

  assign bus.rx_data          = rx_q;
  assign bus.tx_packet_data   = tx_q;
  assign bus.buffer_occupancy = occ;
  assign bus.overflow         = ovf;
  assign bus.underflow        = unf;

endmodule

// File: tb/tb_ep_databuffer.sv
// Directed bench for ep_databuffer at NUM_EP=4, DEPTH=64 with hand-computed expectations.
module tb_ep_databuffer;
  import ep_buffer_pkg::*;

  localparam int NUM_EP = 4;
  localparam int DEPTH  = 64;
  localparam int OCC_W  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;

  ep_databuffer_if #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) bus ();
  ep_databuffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [OCC_W-1:0] occ_of(input int ep);
    return bus.buffer_occupancy[ep*OCC_W +: OCC_W];
  endfunction

  task automatic idle();
    bus.ahb_ep = '0;  bus.store_tx_data = 1'b0; bus.tx_data = '0; bus.tx_size = '0;
    bus.get_rx_data = 1'b0; bus.rx_size = '0; bus.clear = 1'b0;
    bus.usb_ep = '0;  bus.store_rx_packet_data = 1'b0; bus.rx_packet_data = '0;
    bus.get_tx_packet_data = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic host_push(input int ep, input logic [31:0] d, input logic [1:0] sz);
    bus.ahb_ep = 2'(ep); bus.store_tx_data = 1'b1; bus.tx_data = d; bus.tx_size = sz;
    tick();
  endtask

  task automatic host_pop(input int ep, input logic [1:0] sz);
    bus.ahb_ep = 2'(ep); bus.get_rx_data = 1'b1; bus.rx_size = sz;
    tick();
  endtask

  task automatic usb_push(input int ep, input logic [7:0] d);
    bus.usb_ep = 2'(ep); bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = d;
    tick();
  endtask

  task automatic usb_pop(input int ep);
    bus.usb_ep = 2'(ep); bus.get_tx_packet_data = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    logic [7:0]  exp_b [4];

    idle();
    #1 rst = 1'b1;
    #2;
    chk("rst_occ", bus.buffer_occupancy, '0);
    chk("rst_ovf", bus.overflow, '0);
    chk("rst_unf", bus.underflow, '0);
    chk("rst_rx", bus.rx_data, '0);
    chk("rst_tx", bus.tx_packet_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Word push, byte-wise drain in little-endian order
    host_push(1, 32'hDDCCBBAA, WORD);
    chk("ep1_occ4", occ_of(1), 7'd4);
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      usb_pop(1);
      chk("ep1_usb_pop", bus.tx_packet_data, exp_b[i]);
    end
    chk("ep1_occ0", occ_of(1), 7'd0);
    tick();
    chk("tx_hold", bus.tx_packet_data, 8'hDD);

    // Fill EP0 to 62, word push refused, half push fills exactly
    for (int i = 0; i < 15; i++) host_push(0, 32'h0403_0201 + 32'(i), WORD);
    host_push(0, 32'h0000_BEEF, HALF);
    chk("ep0_occ62", occ_of(0), 7'd62);
    host_push(0, 32'h1234_5678, WORD);
    chk("ep0_ovf_word", bus.overflow[0], 1'b1);
    chk("ep0_occ62_kept", occ_of(0), 7'd62);
    host_push(0, 32'h0000_CAFE, HALF);
    chk("ep0_occ64", occ_of(0), 7'd64);
    chk("ep0_ovf_sticky", bus.overflow[0], 1'b1);

    // EP2: offset pointers by one so word accesses straddle the wrap, then fill/drain 3 times
    usb_push(2, 8'h5A);
    usb_pop(2);
    chk("ep2_first_byte", bus.tx_packet_data, 8'h5A);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        b = 8'(r*64 + 4*i);
        host_push(2, {b + 8'd3, b + 8'd2, b + 8'd1, b}, WORD);
      end
      chk("ep2_full", occ_of(2), 7'd64);
      for (int i = 0; i < 16; i++) begin
        b = 8'(r*64 + 4*i);
        w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        host_pop(2, WORD);
        chk("ep2_drain_word", bus.rx_data, w);
      end
      chk("ep2_empty", occ_of(2), 7'd0);
    end
    usb_push(2, 8'h99);
    host_pop(2, HALF);
    chk("ep2_short_pop_rx", bus.rx_data, 32'h0);
    chk("ep2_unf", bus.underflow[2], 1'b1);
    chk("ep2_occ1", occ_of(2), 7'd1);

    // Same-cycle host and USB push to EP3: USB wins
    bus.ahb_ep = 2'd3; bus.store_tx_data = 1'b1; bus.tx_data = 32'h11; bus.tx_size = BYTE;
    bus.usb_ep = 2'd3; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h22;
    tick();
    chk("ep3_occ1", occ_of(3), 7'd1);
    chk("ep3_ovf", bus.overflow[3], 1'b1);
    // Push and pop together at occupancy 1
    bus.ahb_ep = 2'd3; bus.get_rx_data = 1'b1; bus.rx_size = BYTE;
    bus.usb_ep = 2'd3; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h33;
    tick();
    chk("ep3_popped_22", bus.rx_data, 32'h22);
    chk("ep3_occ_stays1", occ_of(3), 7'd1);
    usb_pop(3);
    chk("ep3_tx_33", bus.tx_packet_data, 8'h33);
    host_push(3, 32'hFFFF_FFFF, 2'b11);
    chk("ep3_illegal_noop", occ_of(3), 7'd0);

    // Same-cycle pops on EP1: USB wins, host refused
    host_push(1, 32'h0000_4455, HALF);
    bus.ahb_ep = 2'd1; bus.get_rx_data = 1'b1; bus.rx_size = BYTE;
    bus.usb_ep = 2'd1; bus.get_tx_packet_data = 1'b1;
    tick();
    chk("ep1_usb_pop_wins", bus.tx_packet_data, 8'h55);
    chk("ep1_host_refused_rx", bus.rx_data, 32'h0);
    chk("ep1_unf", bus.underflow[1], 1'b1);
    chk("ep1_occ1", occ_of(1), 7'd1);
    // Different endpoints in one cycle are independent
    bus.ahb_ep = 2'd1; bus.get_rx_data = 1'b1; bus.rx_size = BYTE;
    bus.usb_ep = 2'd3; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h66;
    tick();
    chk("indep_rx_44", bus.rx_data, 32'h44);
    chk("indep_ep1_occ0", occ_of(1), 7'd0);
    chk("indep_ep3_occ1", occ_of(3), 7'd1);

    // Flush beats a host push and keeps flags; clear zeroes flags
    bus.ahb_ep = 2'd0; bus.store_tx_data = 1'b1; bus.tx_data = 32'hA5A5_A5A5; bus.tx_size = WORD;
    bus.usb_ep = 2'd0; bus.flush = 1'b1;
    tick();
    chk("flush_occ0", occ_of(0), 7'd0);
    chk("flush_ovf_kept", bus.overflow[0], 1'b1);
    bus.ahb_ep = 2'd0; bus.clear = 1'b1;
    tick();
    chk("clear_ovf0", bus.overflow[0], 1'b0);
    usb_pop(0);
    chk("empty_usb_pop_tx", bus.tx_packet_data, 8'h00);
    chk("empty_usb_pop_unf", bus.underflow[0], 1'b1);
    chk("pre_rst_ovf", bus.overflow, 4'b1000);
    chk("pre_rst_unf", bus.underflow, 4'b0111);

    // Asynchronous reset in the middle of traffic
    bus.ahb_ep = 2'd1; bus.store_tx_data = 1'b1; bus.tx_data = 32'h0102_0304; bus.tx_size = WORD;
    bus.usb_ep = 2'd3; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", bus.buffer_occupancy, '0);
    chk("arst_ovf", bus.overflow, '0);
    chk("arst_unf", bus.underflow, '0);
    chk("arst_rx", bus.rx_data, '0);
    chk("arst_tx", bus.tx_packet_data, '0);
    @(posedge clk);
    #1;
    chk("arst_inflight_dropped", bus.buffer_occupancy, '0);
    idle();
    rst = 1'b0;
    usb_push(3, 8'h77);
    chk("post_rst_occ3", occ_of(3), 7'd1);
    usb_pop(3);
    chk("post_rst_tx", bus.tx_packet_data, 8'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ep_databuffer.md
EP_DATABUFFER -- requirements
Module: ep_databuffer

Interface
REQ-001 Parameter NUM_EP, default 4, number of independent endpoint byte FIFOs (1..8).
REQ-002 Parameter DEPTH, default 64, bytes per endpoint FIFO (power of two, 8..256).
REQ-003 Derived: EP_W = max(1, clog2(NUM_EP)); OCC_W = clog2(DEPTH)+1.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ahb_ep  in  EP_W  endpoint addressed by the host side
- store_tx_data  in  1  host push of tx_size bytes from tx_data
- tx_data  in  32  host write data, little-endian, byte 0 pushed first
- tx_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal (treated as no-op)
- get_rx_data  in  1  host pop of rx_size bytes
- rx_size  in  2  same encoding as tx_size
- rx_data  out  32  host read data, zero-extended
- clear  in  1  host clear of endpoint ahb_ep
- usb_ep  in  EP_W  endpoint addressed by the USB side
- store_rx_packet_data  in  1  USB push of one byte
- rx_packet_data  in  8  USB write byte
- get_tx_packet_data  in  1  USB pop of one byte
- tx_packet_data  out  8  USB read byte
- flush  in  1  USB flush of endpoint usb_ep
- buffer_occupancy  out  NUM_EP*OCC_W  packed per-endpoint byte counts, EP0 in LSBs
- overflow  out  NUM_EP  sticky per-endpoint dropped-push flag
- underflow  out  NUM_EP  sticky per-endpoint refused-pop flag

Function
REQ-005 Each endpoint SHALL be a circular byte FIFO with read and write pointers that wrap modulo DEPTH, and occupancy ranging 0..DEPTH.
REQ-006 Host push: all N bytes SHALL be written in one cycle if free space (pre-cycle) >= N; otherwise no byte is written and overflow[ahb_ep] is set.
REQ-007 Host pop: if occupancy (pre-cycle) >= N, N bytes are popped and rx_data shows them on the next cycle (byte 0 in [7:0]); otherwise nothing is popped, rx_data = 0, and underflow[ahb_ep] is set.
REQ-008 USB push: one byte SHALL be written if the endpoint is not full; otherwise it is dropped and overflow[usb_ep] is set.
REQ-009 USB pop: if not empty, the head byte SHALL appear on tx_packet_data on the next cycle; otherwise tx_packet_data = 0 and underflow[usb_ep] is set.
REQ-010 rx_data and tx_packet_data SHALL hold their last value when no pop occurs.
REQ-011 buffer_occupancy SHALL reflect all operations of a cycle on the next cycle.
REQ-012 A push and a pop to the same endpoint in one cycle SHALL both proceed, each checked against pre-cycle occupancy, so a byte pushed in a cycle cannot be popped in that cycle; net occupancy = old + pushed - popped.
REQ-013 Two pushes to the same endpoint in one cycle: the USB push wins; the host push is dropped and sets overflow.
REQ-014 Two pops from the same endpoint in one cycle: the USB pop wins; the host pop is refused, rx_data = 0, and underflow is set.
REQ-015 Operations on different endpoints in the same cycle SHALL be fully independent.
REQ-016 clear SHALL zero the pointers, occupancy, overflow and underflow of ahb_ep.
REQ-017 flush SHALL zero the pointers and occupancy of usb_ep, and SHALL leave its flags unchanged.
REQ-018 clear and flush SHALL override any push or pop to the same endpoint in that cycle; the override takes effect on the next cycle.
REQ-019 Storage contents SHALL NOT be reset; only pointers, counts, flags and output registers are reset.

Reset
REQ-020 On rst assertion, asynchronously: all pointers = 0, buffer_occupancy = 0, overflow = 0, underflow = 0, rx_data = 0, tx_packet_data = 0.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight push or pop; the first operation is accepted on the first clk edge after rst deasserts.

Structure
REQ-022 Package ep_buffer_pkg SHALL hold the xfer_size_t enum (BYTE, HALF, WORD) and the default NUM_EP and DEPTH constants.
REQ-023 Sub-module ep_fifo_ctrl (one instance per endpoint via generate) SHALL own the pointers, occupancy and flags; byte storage is a shared array in ep_databuffer.

Verification
REQ-024 Host WORD push of 0xDDCCBBAA to EP1, then USB pops 4x from EP1 -> tx_packet_data = AA, BB, CC, DD; occupancy[1] goes 4 to 0.
REQ-025 With DEPTH = 64, fill EP0 to 62, then host WORD push -> dropped, overflow[0] = 1, occupancy stays 62; then a HALF push -> accepted, occupancy = 64.
REQ-026 Fill EP2 to DEPTH and drain 3 times (pointer wrap) -> byte order preserved; with occupancy = 1, host HALF pop -> rx_data = 0, underflow[2] = 1.
REQ-027 Same cycle on EP3, host BYTE push 0x11 and USB push 0x22 -> only 0x22 stored, overflow[3] = 1; push and pop on EP3 at occupancy 1 -> occupancy stays 1.
REQ-028 flush on EP0 while a host push targets EP0 -> occupancy[0] = 0 and overflow[0] kept; assert rst mid-traffic -> all outputs 0 immediately.
